ex_wb_stage: RTL and testbench

// - Execute->Writeback pipeline register of the 3-stage RV32I core. Sits directly downstream of the ALU.
// - Captures the ALU result, overflow flag, rd and writeback controls, then selects the writeback data (ALU/mem/PC+4).
// - Drives the register-file write port and the EX operand-forwarding selects.
// - Keeps a sticky, saturating ALU-overflow event counter for debug/UART readout.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/ex_wb_stage_fwd_unit.sv | 26 ++
 rtl/ex_wb_stage.sv | 144 ++++++++++++++
 tb/tb_ex_wb_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 3-stage RV32I core.
// Holds the writeback-source select encoding and the hard-wired zero register index.
// BUS_WIDTH is not defined here; it is a parameter of the modules that carry the datapath.
package pipe_pkg;

    // Writeback data source; the unused encoding 3 falls back to the ALU result.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_wb_stage_fwd_unit.sv
// fwd_unit: purely combinational EX operand-forwarding compare.
// Ports:
//   valid_i, we_i, rd_i  - producer in WB (valid, writes rd, destination)
//   rs1_i, rs2_i         - consumer source registers in EX
//   fwd_a_o, fwd_b_o     - operand A / B should take the WB data
// Also instantiated by the hazard logic, so it carries no stall gating.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic       valid_i,
    input  logic       we_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       fwd_a_o,
    output logic       fwd_b_o
);

    logic producer_c;

    // x0 never produces a value worth forwarding.
    assign producer_c = valid_i & we_i & (rd_i != REG_ZERO);
    assign fwd_a_o    = producer_c & (rd_i == rs1_i);
    assign fwd_b_o    = producer_c & (rd_i == rs2_i);

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: Execute->Writeback pipeline register of the 3-stage RV32I core.
// Captures ALU result, overflow flag, rd and writeback controls; selects the
// writeback data; drives the RF write port and EX forwarding selects; keeps a
// sticky saturating ALU-overflow event counter.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   valid_i/stall_i/flush_i  - EX valid, hold stage, kill incoming instruction
//   alu_out_i, ovf_i, pc4_i  - ALU result, overflow flag, link address
//   rd_i, reg_wr_i, wb_sel_i - writeback destination and controls
//   mem_rdata_i              - data-memory read data (valid in WB cycle)
//   rs1_i, rs2_i             - EX source registers for forwarding
//   rf_we_o/rf_waddr_o/rf_wdata_o - register-file write port
//   fwd_a_o, fwd_b_o         - EX operand forwarding selects
//   ovf_sticky_o, ovf_count_o, ovf_clr_i - overflow debug counter
module ex_wb_stage
    import pipe_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [BUS_WIDTH-1:0] alu_out_i,
    input  logic                 ovf_i,
    input  logic [BUS_WIDTH-1:0] pc4_i,
    input  logic [4:0]           rd_i,
    input  logic                 reg_wr_i,
    input  logic [1:0]           wb_sel_i,
    input  logic [BUS_WIDTH-1:0] mem_rdata_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [BUS_WIDTH-1:0] rf_wdata_o,
    output logic                 fwd_a_o,
    output logic                 fwd_b_o,
    output logic                 ovf_sticky_o,
    output logic [CNT_W-1:0]     ovf_count_o,
    input  logic                 ovf_clr_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 valid_q,  valid_d;
    logic                 reg_wr_q, reg_wr_d;
    logic [4:0]           rd_q,     rd_d;
    logic [1:0]           wb_sel_q, wb_sel_d;
    logic [BUS_WIDTH-1:0] alu_q,    alu_d;
    logic [BUS_WIDTH-1:0] pc4_q,    pc4_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 load_c;
    logic                 ovf_event_c;

    // Stage capture: flush beats stall, stall holds everything.
    always_comb begin
        valid_d  = valid_q;
        reg_wr_d = reg_wr_q;
        rd_d     = rd_q;
        wb_sel_d = wb_sel_q;
        alu_d    = alu_q;
        pc4_d    = pc4_q;
        load_c   = 1'b0;
        if (flush_i) begin
            valid_d  = 1'b0;
            reg_wr_d = 1'b0;
        end else if (!stall_i) begin
            load_c   = 1'b1;
            valid_d  = valid_i;
            reg_wr_d = reg_wr_i;
            rd_d     = rd_i;
            wb_sel_d = wb_sel_i;
            alu_d    = alu_out_i;
            pc4_d    = pc4_i;
        end
    end

    // Overflow counter: only ALU-writeback instructions actually loaded count.
    always_comb begin
        ovf_event_c = load_c & valid_i & ovf_i & (wb_sel_i == WB_ALU);
        sticky_d    = sticky_q;
        count_d     = count_q;
        if (ovf_clr_i) begin
            sticky_d = ovf_event_c;
            count_d  = ovf_event_c ? CNT_W'(1) : '0;
        end else if (ovf_event_c) begin
            sticky_d = 1'b1;
            count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            reg_wr_q <= 1'b0;
            rd_q     <= REG_ZERO;
            wb_sel_q <= WB_ALU;
            alu_q    <= '0;
            pc4_q    <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            reg_wr_q <= reg_wr_d;
            rd_q     <= rd_d;
            wb_sel_q <= wb_sel_d;
            alu_q    <= alu_d;
            pc4_q    <= pc4_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // Writeback source mux; memory data arrives from the sync RAM this cycle.
    always_comb begin
        rf_wdata_o = alu_q;
        case (wb_sel_q)
            WB_MEM:  rf_wdata_o = mem_rdata_i;
            WB_PC4:  rf_wdata_o = pc4_q;
            default: rf_wdata_o = alu_q;
        endcase
    end

    // A stalled instruction writes only once, on its final un-stalled cycle;
    // the reset cycle itself must not write either.
    assign rf_we_o      = valid_q & reg_wr_q & (rd_q != REG_ZERO) & ~stall_i & ~rst;
    assign rf_waddr_o   = rd_q;
    assign ovf_sticky_o = sticky_q;
    assign ovf_count_o  = count_q;

    fwd_unit u_fwd (
        .valid_i (valid_q),
        .we_i    (reg_wr_q),
        .rd_i    (rd_q),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .fwd_a_o (fwd_a_o),
        .fwd_b_o (fwd_b_o)
    );

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed scenarios plus randomized traffic checked
// against a slot-level behavioural model of the WB stage (CNT_W=2 so
// counter saturation is reachable).
module tb_ex_wb_stage;
    import pipe_pkg::*;

    localparam int unsigned BW = 32;
    localparam int unsigned CW = 2;
    localparam int          CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, stall_i, flush_i, ovf_i, reg_wr_i, ovf_clr_i;
    logic [BW-1:0] alu_out_i, pc4_i, mem_rdata_i;
    logic [4:0]    rd_i, rs1_i, rs2_i;
    logic [1:0]    wb_sel_i;
    logic          rf_we_o, fwd_a_o, fwd_b_o, ovf_sticky_o;
    logic [4:0]    rf_waddr_o;
    logic [BW-1:0] rf_wdata_o;
    logic [CW-1:0] ovf_count_o;

    int checks = 0;
    int errors = 0;

    // Model of the instruction sitting in WB plus the debug counter.
    bit          m_valid, m_wr, m_known, m_sticky;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_pc4;
    int          m_cnt;

    always #5 clk = ~clk;

    ex_wb_stage #(.BUS_WIDTH(BW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .alu_out_i(alu_out_i), .ovf_i(ovf_i), .pc4_i(pc4_i), .rd_i(rd_i),
        .reg_wr_i(reg_wr_i), .wb_sel_i(wb_sel_i), .mem_rdata_i(mem_rdata_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .ovf_sticky_o(ovf_sticky_o), .ovf_count_o(ovf_count_o), .ovf_clr_i(ovf_clr_i)
    );

    task automatic set_idle();
        rst = 1'b0; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; ovf_i = 1'b0;
        reg_wr_i = 1'b0; ovf_clr_i = 1'b0; alu_out_i = '0; pc4_i = '0;
        mem_rdata_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; wb_sel_i = 2'd0;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] pc4);
        valid_i = 1'b1; reg_wr_i = 1'b1; rd_i = rd; wb_sel_i = sel;
        alu_out_i = alu; pc4_i = pc4;
    endtask

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick();
        bit ev;
        @(posedge clk);
        ev = !rst && !flush_i && !stall_i && valid_i && ovf_i && (wb_sel_i == 2'd0);
        if (rst) begin
            m_valid = 0; m_wr = 0; m_rd = 0; m_sel = 0; m_alu = 0; m_pc4 = 0;
            m_known = 1; m_cnt = 0; m_sticky = 0;
        end else begin
            if (flush_i) begin
                m_valid = 0; m_wr = 0; m_known = 0;
            end else if (!stall_i) begin
                m_valid = valid_i; m_wr = reg_wr_i; m_rd = rd_i; m_sel = wb_sel_i;
                m_alu = alu_out_i; m_pc4 = pc4_i; m_known = 1;
            end
            if (ovf_clr_i) begin
                m_cnt = ev ? 1 : 0; m_sticky = ev;
            end else if (ev) begin
                m_cnt = (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1; m_sticky = 1;
            end
        end
        #1;
    endtask

    function automatic bit e_we();
        return m_valid && m_wr && (m_rd != 5'd0) && !stall_i && !rst;
    endfunction

    function automatic logic [31:0] e_wdata();
        if (m_sel == 2'd1) return mem_rdata_i;
        if (m_sel == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    function automatic bit e_fwd(input logic [4:0] rs);
        return m_valid && m_wr && (m_rd != 5'd0) && (m_rd == rs);
    endfunction

    task automatic test_reset();
        set_idle(); rst = 1'b1;
        tick(); tick();
        rst = 1'b0; mem_rdata_i = 32'hFFFF_FFFF; #1;
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rf_we_o); end
        checks++; if (rf_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr_o); end
        checks++; if (rf_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata_o); end
        checks++; if (fwd_a_o !== 1'b0 || fwd_b_o !== 1'b0) begin errors++; $display("FAIL reset_fwd got %0b%0b exp 00", fwd_a_o, fwd_b_o); end
        checks++; if (ovf_sticky_o !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b exp 0", ovf_sticky_o); end
        checks++; if (ovf_count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ovf_count_o); end
    endtask

    task automatic test_alu_wb();
        set_idle(); set_instr(5'd5, 2'd0, 32'h0000_0010, 32'h0000_1004);
        tick();
        set_idle(); #1;
        checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL alu_we got %0b exp 1", rf_we_o); end
        checks++; if (rf_waddr_o !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d exp 5", rf_waddr_o); end
        checks++; if (rf_wdata_o !== 32'h10) begin errors++; $display("FAIL alu_wdata got %h exp 10", rf_wdata_o); end
        // Link address path.
        set_instr(5'd1, 2'd2, 32'h1234_5678, 32'h0000_2008);
        tick();
        set_idle(); #1;
        checks++; if (rf_wdata_o !== 32'h0000_2008) begin errors++; $display("FAIL pc4_wdata got %h exp 00002008", rf_wdata_o); end
        // Unused select encoding falls back to ALU.
        set_instr(5'd2, 2'd3, 32'hCAFE_0003, 32'h0000_300C);
        tick();
        set_idle(); mem_rdata_i = 32'h1111_1111; #1;
        checks++; if (rf_wdata_o !== 32'hCAFE_0003) begin errors++; $display("FAIL sel3_wdata got %h exp cafe0003", rf_wdata_o); end
    endtask

    task automatic test_x0();
        set_idle(); set_instr(5'd0, 2'd0, 32'h0000_0077, 32'h0);
        tick();
        set_idle(); rs1_i = 5'd0; rs2_i = 5'd0; #1;
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_we got %0b exp 0", rf_we_o); end
        checks++; if (fwd_a_o !== 1'b0) begin errors++; $display("FAIL x0_fwd_a got %0b exp 0", fwd_a_o); end
    endtask

    task automatic test_forward();
        set_idle(); set_instr(5'd7, 2'd1, 32'h0000_0100, 32'h0);
        tick();
        set_idle(); rs1_i = 5'd7; rs2_i = 5'd7; mem_rdata_i = 32'hDEAD_BEEF; #1;
        checks++; if (fwd_a_o !== 1'b1 || fwd_b_o !== 1'b1) begin errors++; $display("FAIL fwd_ab got %0b%0b exp 11", fwd_a_o, fwd_b_o); end
        checks++; if (rf_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_wdata got %h exp deadbeef", rf_wdata_o); end
        rs2_i = 5'd6; #1;
        checks++; if (fwd_a_o !== 1'b1 || fwd_b_o !== 1'b0) begin errors++; $display("FAIL fwd_b_only got %0b%0b exp 10", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_stall_flush();
        set_idle(); set_instr(5'd3, 2'd0, 32'h0000_0055, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_idle(); stall_i = 1'b1; alu_out_i = 32'hBAD0_0000 + 32'(i); rd_i = 5'd9;
            valid_i = 1'b1; reg_wr_i = 1'b1; #1;
            checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL stall%0d_we got %0b exp 0", i, rf_we_o); end
            checks++; if (rf_waddr_o !== 5'd3) begin errors++; $display("FAIL stall%0d_waddr got %0d exp 3", i, rf_waddr_o); end
            checks++; if (rf_wdata_o !== 32'h55) begin errors++; $display("FAIL stall%0d_wdata got %h exp 55", i, rf_wdata_o); end
            tick();
        end
        set_idle(); #1;
        checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL unstall_we got %0b exp 1", rf_we_o); end
        set_idle(); set_instr(5'd3, 2'd0, 32'h66, 32'h0); flush_i = 1'b1; stall_i = 1'b1;
        tick();
        set_idle(); rs1_i = 5'd3; #1;
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL flush_we got %0b exp 0", rf_we_o); end
        checks++; if (fwd_a_o !== 1'b0) begin errors++; $display("FAIL flush_fwd got %0b exp 0", fwd_a_o); end
    endtask

    task automatic test_overflow();
        int seq [4];
        seq = '{1, 2, 3, 3};
        set_idle(); ovf_clr_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_idle(); valid_i = 1'b1; ovf_i = 1'b1;
            tick();
            set_idle(); #1;
            checks++; if (ovf_count_o !== 2'(seq[i]) || ovf_sticky_o !== 1'b1) begin
                errors++; $display("FAIL ovf_seq%0d got %0d/%0b exp %0d/1", i, ovf_count_o, ovf_sticky_o, seq[i]); end
        end
        set_idle(); valid_i = 1'b1; ovf_i = 1'b1; ovf_clr_i = 1'b1;
        tick();
        set_idle(); #1;
        checks++; if (ovf_count_o !== 2'd1 || ovf_sticky_o !== 1'b1) begin errors++; $display("FAIL ovf_clr_ev got %0d/%0b exp 1/1", ovf_count_o, ovf_sticky_o); end
        set_idle(); valid_i = 1'b1; ovf_i = 1'b1; flush_i = 1'b1;
        tick();
        set_idle(); valid_i = 1'b1; ovf_i = 1'b1; stall_i = 1'b1;
        tick();
        set_idle(); valid_i = 1'b1; ovf_i = 1'b1; wb_sel_i = 2'd1;
        tick();
        set_idle(); #1;
        checks++; if (ovf_count_o !== 2'd1) begin errors++; $display("FAIL ovf_ignored got %0d exp 1", ovf_count_o); end
        set_idle(); ovf_clr_i = 1'b1;
        tick();
        set_idle(); #1;
        checks++; if (ovf_count_o !== 2'd0 || ovf_sticky_o !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0d/%0b exp 0/0", ovf_count_o, ovf_sticky_o); end
    endtask

    task automatic test_reset_mid();
        set_idle(); set_instr(5'd9, 2'd0, 32'h0000_ABCD, 32'h0); ovf_i = 1'b1;
        tick();
        set_idle(); rst = 1'b1; #1;
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL rstcyc_we got %0b exp 0", rf_we_o); end
        tick();
        set_idle(); rs1_i = 5'd9; #1;
        checks++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'h0 || fwd_a_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_out got we=%0b a=%0d d=%h f=%0b exp all 0", rf_we_o, rf_waddr_o, rf_wdata_o, fwd_a_o); end
        checks++; if (ovf_count_o !== 2'd0 || ovf_sticky_o !== 1'b0) begin errors++; $display("FAIL rstmid_cnt got %0d/%0b exp 0/0", ovf_count_o, ovf_sticky_o); end
        set_instr(5'd4, 2'd0, 32'h0000_0099, 32'h0);
        tick();
        set_idle(); #1;
        checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd4 || rf_wdata_o !== 32'h99) begin
            errors++; $display("FAIL rst_resume got we=%0b a=%0d d=%h exp 1/4/99", rf_we_o, rf_waddr_o, rf_wdata_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            valid_i = ($urandom_range(0, 3) != 0);
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            ovf_i = $urandom_range(0, 1);
            ovf_clr_i = ($urandom_range(0, 15) == 0);
            reg_wr_i = $urandom_range(0, 1);
            wb_sel_i = 2'($urandom_range(0, 3));
            rd_i = 5'($urandom_range(0, 7));
            rs1_i = 5'($urandom_range(0, 7));
            rs2_i = 5'($urandom_range(0, 7));
            alu_out_i = $urandom(); pc4_i = $urandom(); mem_rdata_i = $urandom();
            #1;
            checks++; if (rf_we_o !== e_we()) begin errors++; $display("FAIL rnd%0d_we got %0b exp %0b", n, rf_we_o, e_we()); end
            checks++; if (fwd_a_o !== e_fwd(rs1_i) || fwd_b_o !== e_fwd(rs2_i)) begin
                errors++; $display("FAIL rnd%0d_fwd got %0b%0b exp %0b%0b", n, fwd_a_o, fwd_b_o, e_fwd(rs1_i), e_fwd(rs2_i)); end
            checks++; if (ovf_count_o !== 2'(m_cnt) || ovf_sticky_o !== m_sticky) begin
                errors++; $display("FAIL rnd%0d_ovf got %0d/%0b exp %0d/%0b", n, ovf_count_o, ovf_sticky_o, m_cnt, m_sticky); end
            if (m_known) begin
                checks++; if (rf_waddr_o !== m_rd || rf_wdata_o !== e_wdata()) begin
                    errors++; $display("FAIL rnd%0d_data got %0d/%h exp %0d/%h", n, rf_waddr_o, rf_wdata_o, m_rd, e_wdata()); end
            end
            tick();
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_alu_wb();
        test_x0();
        test_forward();
        test_stall_flush();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
